// File: rtl/round_seq_ctrl_if.sv
// Handshake and datapath-control bundle for round_seq_ctrl.
// The master side is the requester/consumer pair that also observes the enables.
// The slave side is the controller itself.
// The optional abort/aborted pair exists only when ROUND_SEQ_ABORT_EN is defined.
interface round_seq_ctrl_if #(
    parameter int ROUND_W = 4
);
    logic [ROUND_W-1:0] cfg_rounds;
    logic               in_valid;
    logic               in_ready;
    logic               ld_en;
    logic               rnd_en;
    logic               fin_en;
    logic [ROUND_W-1:0] rnd_idx;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
`ifdef ROUND_SEQ_ABORT_EN
    logic               abort;
    logic               aborted;

    modport master (
        output cfg_rounds, in_valid, out_ready, abort,
        input  in_ready, ld_en, rnd_en, fin_en, rnd_idx, out_valid, busy, aborted
    );

    modport slave (
        input  cfg_rounds, in_valid, out_ready, abort,
        output in_ready, ld_en, rnd_en, fin_en, rnd_idx, out_valid, busy, aborted
    );
`else
    modport master (
        output cfg_rounds, in_valid, out_ready,
        input  in_ready, ld_en, rnd_en, fin_en, rnd_idx, out_valid, busy
    );

    modport slave (
        input  cfg_rounds, in_valid, out_ready,
        output in_ready, ld_en, rnd_en, fin_en, rnd_idx, out_valid, busy
    );
`endif
endinterface

// File: rtl/round_seq_ctrl.sv
// Control FSM that steps one block through the iterative cipher datapath:
// LOAD, R round steps, FINAL, then holds the result in DONE until it is taken.
// R is the per-block round count, clamped to MAX_ROUNDS when the block is accepted.
// All outputs are Moore, decoded from the registered state and the round index.
// Optional feature macro: ROUND_SEQ_ABORT_EN adds abort/aborted to the interface.
// abort cancels a block that is in LOAD, ROUND or FINAL.
module round_seq_ctrl #(
    parameter int ROUND_W    = 4,
    parameter int MAX_ROUNDS = 10
) (
    input  logic            clk,
    input  logic            rst,
    round_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } state_e;

    localparam logic [ROUND_W-1:0] MAX_R = ROUND_W'(MAX_ROUNDS);
    localparam logic [ROUND_W-1:0] ONE_R = ROUND_W'(1);

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] cnt_q, cnt_d;
    logic [ROUND_W-1:0] idx_q, idx_d;
    logic [ROUND_W-1:0] cfg_clamped;
`ifdef ROUND_SEQ_ABORT_EN
    logic               aborted_q, aborted_d;
`endif

    // Clamp the requested round count so the counter and index never exceed MAX_ROUNDS
    always_comb begin
        cfg_clamped = (bus.cfg_rounds > MAX_R) ? MAX_R : bus.cfg_rounds;
    end

    // State, down counter and round index registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
`ifdef ROUND_SEQ_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
`ifdef ROUND_SEQ_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    // Next-state logic: the counter holds the rounds still to do, the index counts rounds done
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
`ifdef ROUND_SEQ_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = LOAD;
                    cnt_d   = cfg_clamped;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                state_d = (cnt_q == '0) ? FINAL : ROUND;
            end
            ROUND: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE_R;
                    idx_d = idx_q + ONE_R;
                end
                if (cnt_q <= ONE_R) begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
`ifdef ROUND_SEQ_ABORT_EN
        if (bus.abort && ((state_q == LOAD) || (state_q == ROUND) || (state_q == FINAL))) begin
            state_d   = IDLE;
            cnt_d     = '0;
            idx_d     = '0;
            aborted_d = 1'b1;
        end
`endif
    end

    // Moore output decode: exactly one datapath enable per active state, none in IDLE or DONE
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.ld_en     = 1'b0;
        bus.rnd_en    = 1'b0;
        bus.fin_en    = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state_q != IDLE);
        bus.rnd_idx   = idx_q;
`ifdef ROUND_SEQ_ABORT_EN
        bus.aborted   = aborted_q;
`endif
        case (state_q)
            IDLE:    bus.in_ready  = 1'b1;
            LOAD:    bus.ld_en     = 1'b1;
            ROUND:   bus.rnd_en    = 1'b1;
            FINAL:   bus.fin_en    = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: bus.in_ready  = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_round_seq_ctrl.sv
// Self-checking bench for round_seq_ctrl.
// A cycle-offset model derived from the handshake timing rules predicts every output each cycle.
// Directed blocks add literal checks on round counts, final index and latency.
// Abort scenarios are included when ROUND_SEQ_ABORT_EN is defined.
module tb_round_seq_ctrl;

    localparam int ROUND_W    = 4;
    localparam int MAX_ROUNDS = 10;

    logic clk;
    logic rst;

    int tests_run = 0;
    int tests_failed = 0;

    // model state
    int cyc = 0;
    bit m_known = 0;
    bit m_active = 0;
    int m_start = 0;
    int m_r = 0;
    bit m_abort_pulse = 0;
    bit m_abort_hit = 0;
    int m_e = 0;
    int cmp_e = 0;

    // per-block monitor
    int rnd_count = 0;
    int fin_idx = -1;
    int ld_cyc = 0;
    int ld_to_ov = -1;
    bit ov_seen = 0;

    round_seq_ctrl_if #(.ROUND_W(ROUND_W)) bus ();

    round_seq_ctrl #(
        .ROUND_W    (ROUND_W),
        .MAX_ROUNDS (MAX_ROUNDS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit valid, input int rounds, input bit ordy);
        bus.in_valid   = valid;
        bus.cfg_rounds = ROUND_W'(rounds);
        bus.out_ready  = ordy;
    endtask

    task automatic waitOutValid();
        bit got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            tick(1);
            if (bus.out_valid === 1'b1) got = 1;
        end
        checkOutput("wait_out_valid", 32'(got), 32'd1);
    endtask

    task automatic checkBlock(input string name, input int exp_rounds, input int exp_fin_idx, input int exp_lat);
        checkOutput({name, "_rnd_count"}, 32'(rnd_count), 32'(exp_rounds));
        checkOutput({name, "_fin_idx"}, 32'(fin_idx), 32'(exp_fin_idx));
        checkOutput({name, "_ld_to_ov"}, 32'(ld_to_ov), 32'(exp_lat));
    endtask

    // Model: tracks how many edges have passed since the accepting handshake
    always @(posedge clk) begin
        if (!rst) begin
            m_known       = 1;
            m_active      = 0;
            m_abort_pulse = 0;
        end else begin
            m_abort_pulse = 0;
            if (m_active) begin
                m_e = cyc - m_start;
                m_abort_hit = 0;
`ifdef ROUND_SEQ_ABORT_EN
                m_abort_hit = (bus.abort === 1'b1) && (m_e <= m_r + 1);
`endif
                if (m_abort_hit) begin
                    m_active      = 0;
                    m_abort_pulse = 1;
                end else if (m_e >= m_r + 2 && bus.out_ready === 1'b1) begin
                    m_active = 0;
                end
            end else if (bus.in_valid === 1'b1) begin
                m_active = 1;
                m_start  = cyc + 1;
                m_r      = (int'(bus.cfg_rounds) > MAX_ROUNDS) ? MAX_ROUNDS : int'(bus.cfg_rounds);
            end
        end
        cyc++;
    end

    // Compare every output against the model in the middle of each cycle
    always @(negedge clk) begin
        if (m_known) begin
            cmp_e = cyc - m_start;
            checkOutput("in_ready",  32'(bus.in_ready),  32'(!m_active));
            checkOutput("busy",      32'(bus.busy),      32'(m_active));
            checkOutput("ld_en",     32'(bus.ld_en),     32'(m_active && cmp_e == 0));
            checkOutput("rnd_en",    32'(bus.rnd_en),    32'(m_active && cmp_e >= 1 && cmp_e <= m_r));
            checkOutput("fin_en",    32'(bus.fin_en),    32'(m_active && cmp_e == m_r + 1));
            checkOutput("out_valid", 32'(bus.out_valid), 32'(m_active && cmp_e >= m_r + 2));
            if (m_active) begin
                checkOutput("rnd_idx", 32'(bus.rnd_idx),
                            32'((cmp_e == 0) ? 0 : ((cmp_e <= m_r) ? cmp_e - 1 : m_r)));
            end
`ifdef ROUND_SEQ_ABORT_EN
            checkOutput("aborted", 32'(bus.aborted), 32'(m_abort_pulse));
`endif
        end
    end

    // Per-block monitor for round count, final index and load-to-result latency
    always @(negedge clk) begin
        if (bus.ld_en === 1'b1) begin
            rnd_count = 0;
            fin_idx   = -1;
            ld_cyc    = cyc;
            ov_seen   = 0;
            ld_to_ov  = -1;
        end
        if (bus.rnd_en === 1'b1) rnd_count++;
        if (bus.fin_en === 1'b1) fin_idx = int'(bus.rnd_idx);
        if (bus.out_valid === 1'b1 && !ov_seen) begin
            ov_seen  = 1;
            ld_to_ov = cyc - ld_cyc;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;
        rst = 1'b0;
        applyStimulus(0, 0, 0);
`ifdef ROUND_SEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        tick(3);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_busy",     32'(bus.busy),     32'd0);
        checkOutput("reset_ld_en",    32'(bus.ld_en),    32'd0);
        checkOutput("reset_rnd_idx",  32'(bus.rnd_idx),  32'd0);
        rst = 1'b1;
        tick(1);

        // Three rounds, cfg changes after the handshake and must be ignored
        applyStimulus(1, 3, 1);
        tick(1);
        checkOutput("r3_ld_en", 32'(bus.ld_en), 32'd1);
        applyStimulus(0, 9, 1);
        waitOutValid();
        tick(1);
        checkBlock("r3", 3, 3, 5);

        // Zero rounds: LOAD straight to FINAL
        applyStimulus(1, 0, 1);
        tick(1);
        applyStimulus(0, 0, 1);
        waitOutValid();
        tick(1);
        checkBlock("r0", 0, 0, 2);

        // Over-range count is clamped to MAX_ROUNDS
        applyStimulus(1, 15, 1);
        tick(1);
        applyStimulus(0, 0, 1);
        waitOutValid();
        tick(1);
        checkBlock("r15", 10, 10, 12);

        // Result held in DONE while the consumer stalls, new requests ignored meanwhile
        applyStimulus(1, 2, 0);
        tick(1);
        applyStimulus(0, 2, 0);
        waitOutValid();
        applyStimulus(1, 5, 0);
        tick(5);
        checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_rnd_idx",   32'(bus.rnd_idx),   32'd2);
        applyStimulus(1, 5, 1);
        tick(1);
        checkOutput("release_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("release_out_valid", 32'(bus.out_valid), 32'd0);
        tick(1);
        checkOutput("back2back_ld_en", 32'(bus.ld_en), 32'd1);
        applyStimulus(0, 0, 1);
        waitOutValid();
        tick(1);
        checkBlock("r5", 5, 5, 7);

        // Reset during ROUND discards the block
        applyStimulus(1, 8, 1);
        tick(1);
        applyStimulus(0, 0, 1);
        got = 0;
        for (int i = 0; i < 32 && !got; i++) begin
            tick(1);
            if (rnd_count >= 3 && bus.rnd_en === 1'b1) got = 1;
        end
        checkOutput("wait_fourth_round", 32'(got), 32'd1);
        rst = 1'b0;
        tick(1);
        checkOutput("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("midrst_busy",      32'(bus.busy),      32'd0);
        checkOutput("midrst_rnd_en",    32'(bus.rnd_en),    32'd0);
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_rnd_idx",   32'(bus.rnd_idx),   32'd0);
        rst = 1'b1;
        tick(2);
        applyStimulus(1, 8, 1);
        tick(1);
        applyStimulus(0, 0, 1);
        waitOutValid();
        tick(1);
        checkBlock("r8", 8, 8, 10);

`ifdef ROUND_SEQ_ABORT_EN
        // Abort on the second round cycle cancels the block
        applyStimulus(1, 4, 1);
        tick(1);
        applyStimulus(0, 0, 1);
        got = 0;
        for (int i = 0; i < 16 && !got; i++) begin
            tick(1);
            if (bus.rnd_en === 1'b1 && rnd_count >= 1) got = 1;
        end
        checkOutput("wait_second_round", 32'(got), 32'd1);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        checkOutput("abort_pulse",     32'(bus.aborted),   32'd1);
        checkOutput("abort_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("abort_rnd_idx",   32'(bus.rnd_idx),   32'd0);
        tick(1);
        checkOutput("abort_pulse_end", 32'(bus.aborted),   32'd0);
        checkOutput("abort_no_result", 32'(bus.out_valid), 32'd0);

        // Abort while in DONE is ignored
        applyStimulus(1, 1, 0);
        tick(1);
        applyStimulus(0, 0, 0);
        waitOutValid();
        bus.abort = 1'b1;
        tick(2);
        checkOutput("done_abort_out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("done_abort_aborted",   32'(bus.aborted),   32'd0);
        bus.abort = 1'b0;
        applyStimulus(0, 0, 1);
        tick(1);
        checkOutput("done_abort_release", 32'(bus.in_ready), 32'd1);
`endif

        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/round_seq_ctrl.md
Name: round_seq_ctrl

Overview:
- Control FSM that sequences one block through the iterative cipher datapath: load, N round steps, final step, then result handoff.
- Accepts a block with a per-block round count over a valid/ready handshake.
- Drives the datapath enables (ld_en, rnd_en, fin_en) and the round index used by the key schedule.
- Presents completion over a valid/ready output handshake. Control only; no data path inside.

Parameters:
ROUND_W, 4, width of round count, internal counter and rnd_idx
MAX_ROUNDS, 10, upper clamp on accepted round count; must be < 2**ROUND_W

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
cfg_rounds  input  ROUND_W  round count for the block, sampled on input handshake
in_valid  input  1  requester has a block ready
in_ready  output  1  controller can accept a block
ld_en  output  1  datapath: load input block and key registers
rnd_en  output  1  datapath: perform one round step
fin_en  output  1  datapath: perform final/output step
rnd_idx  output  ROUND_W  rounds completed so far; key-schedule select
out_valid  output  1  result register holds a finished block
out_ready  input  1  consumer takes the result
busy  output  1  high in every state except IDLE

Behaviour:
- Reset, clk and rst: rst is synchronous, active-low; clock clk. rst=0 at an edge puts the FSM in IDLE and clears the counter, rnd_idx and all outputs. in_ready is high in IDLE after reset.
- Reset mid-operation: the in-flight block is discarded and no out_valid is produced.
- Outputs are Moore, decoded from registered state plus registered counter/index.
- States: IDLE, LOAD, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - On in_valid && in_ready: latch R = min(cfg_rounds, MAX_ROUNDS) into the down counter, clear rnd_idx, go to LOAD.
- LOAD:
  - ld_en=1 for exactly one cycle, rnd_idx=0.
  - Next state is ROUND if R>0, otherwise FINAL.
- ROUND:
  - rnd_en=1 every cycle.
  - Each cycle the counter decrements and rnd_idx increments.
  - When the counter equals 1 in a cycle, the next state is FINAL. Exactly R cycles of rnd_en occur.
  - rnd_idx reads 0..R-1 during the R round cycles.
- FINAL: fin_en=1 for one cycle, rnd_idx=R, then go to DONE.
- DONE:
  - out_valid=1, held stable until out_valid && out_ready.
  - On that handshake go to IDLE. rnd_idx holds R until leaving.
- Timing:
  - Handshake at edge N gives: ld_en during cycle N+1, rnd_en during N+2..N+1+R, fin_en during N+2+R, out_valid from N+3+R.
  - Minimum spacing between accepted blocks is R+4 cycles (one IDLE cycle is mandatory).
- Enable exclusivity: at most one of ld_en, rnd_en, fin_en is high in any cycle. None is high in IDLE or DONE.
- in_valid while in_ready=0 is ignored. cfg_rounds is sampled only at the handshake.
- Counter never underflows. rnd_idx never exceeds MAX_ROUNDS.
- cfg_rounds > MAX_ROUNDS is clamped silently.

Optional Feature:
ROUND_SEQ_ABORT_EN:
- Defined: adds input abort (1) and output aborted (1).
  - abort=1 at an edge while in LOAD, ROUND or FINAL moves the FSM to IDLE and clears the counter and rnd_idx.
  - aborted pulses high for one cycle, the cycle after the abort edge.
  - No out_valid is produced for that block.
  - abort in IDLE or DONE is ignored; DONE still completes normally.
  - If abort and rst=0 occur together, rst wins and aborted stays low.
- Undefined: both ports are absent and behaviour is as above.

Test Plan:
- Reset then cfg_rounds=3 with in_valid at edge 0 -> ld_en cycle 1; rnd_en cycles 2-4 with rnd_idx 0,1,2; fin_en cycle 5 with rnd_idx=3; out_valid from cycle 6; in_ready low during cycles 1-6.
- cfg_rounds=0 -> ld_en then fin_en on the next cycle; no rnd_en; out_valid 3 cycles after accept.
- cfg_rounds=15 with MAX_ROUNDS=10 -> exactly 10 rnd_en cycles; rnd_idx peaks at 10 in FINAL.
- out_ready held low 5 cycles in DONE -> out_valid stays high, no enables, in_valid ignored; out_ready=1 -> IDLE next cycle; second block accepted the following edge.
- rst=0 during ROUND (cfg_rounds=8, after 4 rounds) -> next cycle all outputs 0, in_ready=1, no out_valid; next block runs a full 8 rounds.
- ROUND_SEQ_ABORT_EN: abort on 2nd rnd_en cycle -> aborted pulses for one cycle, IDLE, no out_valid; abort in DONE -> ignored.
